// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the 007121 line-buffer read side.
//   LBUF_AW / LBUF_DW : line RAM geometry ({half, column} x {pal, colour})
//   PXL_BLANK         : pixel value shown outside the active line
//   lbuf_st_e         : per-pixel read sub-state
package jtcontra_gfx_pkg;

    localparam int LBUF_AW = 10;
    localparam int LBUF_DW = 8;

    localparam logic [LBUF_DW-1:0] PXL_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        CLR
    } lbuf_st_e;

endpackage

// File: rtl/jtcontra_gfx_lbuf_dpram.sv
// One line-buffer RAM (1024x8 by default).
// Ports:
//   clk                    system clock
//   we_a, addr_a, din_a    port A, write-only (tilemap engine side)
//   en_b, we_b, addr_b,
//   din_b, q_b             port B, registered read or write (scan side)
// Port B only updates q_b on read cycles, so q_b holds the last column
// read while a clear write is in progress.
module jtcontra_gfx_lbuf_dpram
    import jtcontra_gfx_pkg::*;
#(
    parameter int AW = LBUF_AW,
    parameter int DW = LBUF_DW
)(
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    input  logic          en_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Both ports live in one process; the two sides always address
    // opposite line halves, so they never touch the same word.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        if (en_b) begin
            if (we_b) begin
                mem[addr_b] <= din_b;
            end else begin
                q_b <= mem[addr_b];
            end
        end
    end

endmodule

// File: rtl/jtcontra_gfx_linescan.sv
// 007121 tilemap line-buffer scan-out.
// Reads the half of the scroll and fixed line RAMs that the tilemap engine
// is not writing, one column per pixel clock enable, and merges the two
// layers by priority into a palette-indexed pixel.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pxl_cen             pixel clock enable (>= 2 clk apart)
//   LHBL, LVBL          active-low blanking
//   line                half being written by the tilemap engine
//   chr_we, scr_we      fixed / scroll layer write strobes
//   line_addr, line_din {half, column} write address, {pal, colour} data
//   rd_start            first column scanned after each LHBL rise
//   chr_en, scr_en      layer enables
//   pxl, pxl_lyr        merged pixel, 1 = from fixed layer
// Build option: define JTCONTRA_LBUF_CLR_EN to zero each location right
// after it has been scanned, so columns skipped by the tilemap next line
// come out transparent.
module jtcontra_gfx_linescan
    import jtcontra_gfx_pkg::*;
#(
    parameter int                 HW    = 9,
    parameter logic [LBUF_DW-1:0] BLANK = PXL_BLANK
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pxl_cen,
    input  logic               LHBL,
    input  logic               LVBL,
    input  logic               line,
    input  logic               chr_we,
    input  logic               scr_we,
    input  logic [LBUF_AW-1:0] line_addr,
    input  logic [LBUF_DW-1:0] line_din,
    input  logic [HW-1:0]      rd_start,
    input  logic               chr_en,
    input  logic               scr_en,
    output logic [LBUF_DW-1:0] pxl,
    output logic               pxl_lyr
);

    genvar gi;

    lbuf_st_e           state_reg, state_next;
    logic               lhbl_reg;
    logic [HW-1:0]      hcnt_reg;
    logic [LBUF_AW-1:0] rd_addr_reg;
    logic               pend_reg;
    logic [LBUF_DW-1:0] pxl_reg, pxl_next;
    logic               lyr_reg, lyr_next;

    logic               lhbl_rise;
    logic               rd_issue;
    logic               clr_we;
    logic               ram_en_b;
    logic [1:0]         ram_we_a;
    logic [LBUF_DW-1:0] ram_q [2];
    logic [LBUF_DW-1:0] scr_q, chr_q;

    assign lhbl_rise = LHBL & ~lhbl_reg;
    // The counter load takes priority over a coincident pixel enable.
    assign rd_issue  = pxl_cen & LHBL & LVBL & ~lhbl_rise;

`ifdef JTCONTRA_LBUF_CLR_EN
    assign clr_we = (state_reg == CAP);
`else
    assign clr_we = 1'b0;
`endif

    assign ram_en_b = (state_reg == RD) | clr_we;
    assign ram_we_a = {chr_we, scr_we};

    // Index 0 holds the scroll layer, index 1 the fixed layer.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ram
            jtcontra_gfx_lbuf_dpram #(
                .AW (LBUF_AW),
                .DW (LBUF_DW)
            ) u_ram (
                .clk    (clk),
                .we_a   (ram_we_a[gi]),
                .addr_a (line_addr),
                .din_a  (line_din),
                .en_b   (ram_en_b),
                .we_b   (clr_we),
                .addr_b (rd_addr_reg),
                .din_b  ({LBUF_DW{1'b0}}),
                .q_b    (ram_q[gi])
            );
        end
    endgenerate

    assign scr_q = ram_q[0];
    assign chr_q = ram_q[1];

    // Sub-state: a new read may start from any state because the clear
    // write (if any) is committed on the same edge the next read issues.
    always_comb begin
        state_next = IDLE;
        if (rd_issue) begin
            state_next = RD;
        end else begin
            case (state_reg)
`ifdef JTCONTRA_LBUF_CLR_EN
                CAP:     state_next = CLR;
`else
                CAP:     state_next = IDLE;
`endif
                RD:      state_next = CAP;
                default: state_next = IDLE;
            endcase
        end
    end

    // Layer merge for the column read at the previous enable.
    always_comb begin
        pxl_next = BLANK;
        lyr_next = 1'b0;
        if (LHBL && LVBL && pend_reg) begin
            if (chr_en && (chr_q[3:0] != 4'd0)) begin
                pxl_next = chr_q;
                lyr_next = 1'b1;
            end else if (scr_en) begin
                pxl_next = scr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            lhbl_reg    <= 1'b0;
            hcnt_reg    <= '0;
            rd_addr_reg <= '0;
            pend_reg    <= 1'b0;
            pxl_reg     <= BLANK;
            lyr_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            lhbl_reg  <= LHBL;
            if (lhbl_rise) begin
                hcnt_reg <= rd_start;
            end else if (pxl_cen && LHBL) begin
                hcnt_reg <= hcnt_reg + HW'(1);
            end
            if (rd_issue) begin
                rd_addr_reg <= {~line, hcnt_reg};
            end
            if (pxl_cen) begin
                pend_reg <= rd_issue;
                pxl_reg  <= pxl_next;
                lyr_reg  <= lyr_next;
            end
        end
    end

    assign pxl     = pxl_reg;
    assign pxl_lyr = lyr_reg;

endmodule

// File: tb/tb_jtcontra_gfx_linescan.sv
// Scoreboard bench for jtcontra_gfx_linescan. The stimulus process keeps a
// behavioural copy of both line RAMs and predicts every pixel; a monitor
// checks the DUT output after each pixel enable.
module tb_jtcontra_gfx_linescan;

    logic       clk;
    logic       rst_n;
    logic       pxl_cen;
    logic       LHBL;
    logic       LVBL;
    logic       line;
    logic       chr_we;
    logic       scr_we;
    logic [9:0] line_addr;
    logic [7:0] line_din;
    logic [8:0] rd_start;
    logic       chr_en;
    logic       scr_en;
    logic [7:0] pxl;
    logic       pxl_lyr;

    jtcontra_gfx_linescan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .LHBL      (LHBL),
        .LVBL      (LVBL),
        .line      (line),
        .chr_we    (chr_we),
        .scr_we    (scr_we),
        .line_addr (line_addr),
        .line_din  (line_din),
        .rd_start  (rd_start),
        .chr_en    (chr_en),
        .scr_en    (scr_en),
        .pxl       (pxl),
        .pxl_lyr   (pxl_lyr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nlines = 0;

    logic [8:0] exp_q [$];

    // Reference model state
    logic [7:0] m_scr [1024];
    logic [7:0] m_chr [1024];
    logic       m_prev = 1'b0;
    logic       m_pend = 1'b0;
    logic [8:0] m_hcnt = '0;
    logic [7:0] snap_scr = '0;
    logic [7:0] snap_chr = '0;

    function automatic logic [8:0] model_merge(input logic [7:0] c, input logic [7:0] s,
                                               input logic ce, input logic se);
        if (ce && c[3:0] != 4'd0) return {c, 1'b1};
        if (se) return {s, 1'b0};
        return {8'h00, 1'b0};
    endfunction

    // Monitor: the DUT presents a new pixel at every enabled edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            if (pxl_cen && rst_n) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel: got %02h/%0d but no pixel was expected at %0t", pxl, pxl_lyr, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({pxl, pxl_lyr} !== e) begin
                        errors++;
                        $display("FAIL pixel: got %02h/%0d expected %02h/%0d at %0t",
                                 pxl, pxl_lyr, e[8:1], e[0], $time);
                    end
                end
            end
        end
    end

    // One clock of stimulus; inputs other than pxl_cen are set by the caller.
    task automatic tick(input logic cen);
        logic       rise;
        logic [8:0] h_old;
        logic [9:0] a;
        pxl_cen = cen;
        if (!rst_n) begin
            m_prev = 1'b0;
            m_pend = 1'b0;
            m_hcnt = '0;
        end else begin
            rise = LHBL && !m_prev;
            if (cen) begin
                if (LHBL && LVBL && m_pend)
                    exp_q.push_back(model_merge(snap_chr, snap_scr, chr_en, scr_en));
                else
                    exp_q.push_back(9'h000);
            end
            h_old = m_hcnt;
            if (rise) m_hcnt = rd_start;
            else if (cen && LHBL) m_hcnt = m_hcnt + 9'd1;
            if (cen) begin
                if (LHBL && LVBL && !rise) begin
                    a = {~line, h_old};
                    snap_scr = m_scr[a];
                    snap_chr = m_chr[a];
                    m_pend = 1'b1;
`ifdef JTCONTRA_LBUF_CLR_EN
                    m_scr[a] = 8'h00;
                    m_chr[a] = 8'h00;
`endif
                end else begin
                    m_pend = 1'b0;
                end
            end
            if (scr_we) m_scr[line_addr] = line_din;
            if (chr_we) m_chr[line_addr] = line_din;
            m_prev = LHBL;
        end
        @(posedge clk);
        @(negedge clk);
        pxl_cen = 1'b0;
    endtask

    task automatic wr(input logic is_chr, input logic [9:0] a, input logic [7:0] d);
        line_addr = a;
        line_din  = d;
        chr_we    = is_chr;
        scr_we    = !is_chr;
        tick(1'b0);
        chr_we = 1'b0;
        scr_we = 1'b0;
    endtask

    task automatic scan(input logic [8:0] rs, input logic ln, input logic vb, input int n);
        rd_start = rs;
        line     = ln;
        LVBL     = vb;
        LHBL     = 1'b1;
        if ($urandom_range(1, 0) == 1) begin
            tick(1'b1);
            tick(1'b0);
        end else begin
            tick(1'b0);
        end
        for (int k = 0; k < n; k++) begin
            tick(1'b1);
            repeat ($urandom_range(3, 1)) tick(1'b0);
        end
        LHBL = 1'b0;
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        repeat (3) tick(1'b0);
        LVBL = 1'b1;
        nlines++;
        $display("scan %0d: rd_start=%0d read_half=%0d lvbl=%0d cens=%0d chr_en=%0d scr_en=%0d errors=%0d",
                 nlines, rs, !ln, vb, n, chr_en, scr_en, errors);
    endtask

    task automatic chk_reset_out(input string tag);
        checks++;
        if (pxl !== 8'h00) begin
            errors++;
            $display("FAIL %s pxl: got %02h expected 00", tag, pxl);
        end
        checks++;
        if (pxl_lyr !== 1'b0) begin
            errors++;
            $display("FAIL %s pxl_lyr: got %0d expected 0", tag, pxl_lyr);
        end
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b1; line = 1'b0;
        chr_we = 1'b0; scr_we = 1'b0; line_addr = '0; line_din = '0;
        rd_start = '0; chr_en = 1'b0; scr_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk_reset_out("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill both RAMs; half 0 columns 0..319 hold the ramp pattern.
        for (int i = 0; i < 1024; i++) begin
            d = $urandom;
            if (i < 320) d = 8'h10 + {4'h0, 4'(i)};
            wr(1'b0, 10'(i), d);
            d = $urandom;
            if (i < 320 || $urandom_range(3, 0) == 0) d[3:0] = 4'h0;
            wr(1'b1, 10'(i), d);
        end

        // Ramp scan of half 0 and an immediate rescan of the same half.
        chr_en = 1'b0; scr_en = 1'b1;
        scan(9'd0, 1'b1, 1'b1, 320);
        scan(9'd0, 1'b1, 1'b1, 320);

        // Layer priority at columns 5 and 6 of half 1.
        wr(1'b1, 10'd517, 8'h23); wr(1'b0, 10'd517, 8'h47);
        wr(1'b1, 10'd518, 8'h20); wr(1'b0, 10'd518, 8'h47);
        chr_en = 1'b1;
        scan(9'd5, 1'b0, 1'b1, 3);
        wr(1'b1, 10'd517, 8'h23); wr(1'b0, 10'd517, 8'h47);
        chr_en = 1'b0;
        scan(9'd5, 1'b0, 1'b1, 3);

        // Column wrap.
        chr_en = 1'b1;
        scan(9'd510, 1'b0, 1'b1, 6);

        // Vertical blank, then a normal scan of the same columns.
        scan(9'd40, 1'b0, 1'b0, 30);
        scan(9'd40, 1'b0, 1'b1, 30);

        // Reset in the middle of an active line.
        for (int i = 200; i < 204; i++) begin
            wr(1'b1, 10'(512 + i), 8'h5A);
            wr(1'b0, 10'(512 + i), 8'h3C);
        end
        chr_en = 1'b1; scr_en = 1'b1;
        rd_start = 9'd200; line = 1'b0; LVBL = 1'b1; LHBL = 1'b1;
        tick(1'b0);
        repeat (3) begin
            tick(1'b1);
            tick(1'b0);
        end
        repeat (2) tick(1'b0);
        rst_n = 1'b0;
        #1 chk_reset_out("midline_reset");
        rd_start = 9'd210;
        repeat (3) tick(1'b0);
        rst_n = 1'b1;
        repeat (6) begin
            tick(1'b1);
            tick(1'b0);
        end
        LHBL = 1'b0;
        tick(1'b1);
        repeat (3) tick(1'b0);
        nlines++;
        $display("scan %0d: mid-line reset, restart at rd_start=210 errors=%0d", nlines, errors);

        // Random lines with writes into either half between scans.
        for (int l = 0; l < 30; l++) begin
            for (int w = 0; w < 8; w++) begin
                d = $urandom;
                wr($urandom_range(1, 0) == 1, 10'($urandom), d);
            end
            chr_en = 1'($urandom);
            scr_en = 1'($urandom);
            scan(9'($urandom), 1'($urandom), ($urandom_range(9, 0) != 0), $urandom_range(60, 10));
        end

        repeat (4) tick(1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pixels still expected, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
